md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit; sits beside the ALU, directly upstream of the E/M pipeline register.
- Accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction and holds the HI/LO architectural registers.
- Models fixed multi-cycle latency with a busy counter.
- Exposes a stall request to the hazard unit so that dependent md instructions (mfhi/mflo and new md ops) are held in D.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- start  input  1  E-stage instruction is an md op; qualifies op
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- busy  output  1  registered; an operation is in flight
- md_stall  output  1  combinational: busy | (start & op in 1..4)
- HI_out  output  32  registered HI
- LO_out  output  32  registered LO

Behaviour:
- Reset (reset==0, asynchronous): busy=0, count=0, HI_out=0, LO_out=0, pending result=0. Reset asserted mid-operation aborts it; no HI/LO update occurs after release.
- Accepted op: start=1 at a rising edge with busy=0.
- op 1-4 accepted:
  - Compute the 64-bit result from A/B at that edge; hold it in internal pending registers.
  - Load count with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4); busy<=1.
- While busy: each edge decrements count. At the edge where count==1: HI_out/LO_out<=pending, busy<=0, count<=0.
- Net timing: busy is high for exactly N cycles after the accepting edge; new HI/LO become visible in the same cycle busy falls.
- mult: signed 32x32->64; HI=[63:32], LO=[31:0].
- multu: unsigned 32x32->64; HI=[63:32], LO=[31:0].
- div/divu: LO=quotient, HI=remainder; signed div truncates toward zero, remainder takes the sign of the dividend.
- div by zero (B==0, ops 3/4): busy sequence runs normally; HI/LO are left unchanged at completion.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- op 5/6 accepted: HI_out (5) or LO_out (6) <= A at that edge; busy stays 0; no latency.
- start=1 while busy=1: ignored entirely. Operands are not sampled; HI/LO are not written by mthi/mtlo. The hazard unit guarantees this does not occur architecturally via md_stall.
- start=0, or op 0/7: no state change.
- md_stall is high in the accept cycle of op 1-4 and in every busy cycle. It is low in the cycle busy deasserts; that cycle's HI/LO are already final.
- Operands A/B may change freely after the accepting edge.

Test Plan:
1. Reset release → busy=0, HI_out=LO_out=0. Assert reset=0 three cycles after accepting a div → busy falls immediately; HI/LO stay 0 after release.
2. mult with A=0xFFFFFFFE, B=3 → busy high exactly 5 cycles, md_stall high in accept cycle; at busy fall HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
3. div with A=0xFFFFFFF9 (-7), B=2 → busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1.
4. divu with B=0 after HI/LO were loaded with 0x11/0x22 → busy runs 10 cycles; HI=0x11, LO=0x22 unchanged. Signed div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
5. mthi A=0xDEADBEEF, then mtlo A=0x12345678 on consecutive edges → HI_out and LO_out update one edge each; busy never rises. mthi issued while a mult is busy → ignored; mult result lands intact.
6. mult accepted, then a new mult with different operands presented during busy → the second is ignored. Re-present it in the cycle busy falls → accepted; busy high 5 more cycles; final HI/LO match the second operands.

Source files
------------

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: holds HI/LO and models fixed multi-cycle
// latency, raising md_stall so dependent md instructions are held upstream.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    // Returns {remainder, quotient}; the min/-1 case is pinned so it never overflows.
    function automatic logic [63:0] f_sdiv(input logic signed [31:0] n, input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'sd0) begin
            return 64'd0;
        end
        if (n == 32'sh80000000 && d == 32'shFFFFFFFF) begin
            return {32'h0000_0000, 32'h8000_0000};
        end
        q = n / d;
        r = n % d;
        return {r, q};
    endfunction

    function automatic logic [63:0] f_udiv(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'd0) begin
            return 64'd0;
        end
        return {n % d, n / d};
    endfunction

    logic                 r_busy;
    logic [CNT_W-1:0]     r_count;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_pend_wr;

    logic signed [63:0]   w_sprod;
    logic [63:0]          w_uprod;
    logic [63:0]          w_result;
    logic                 w_long_op;
    logic [CNT_W-1:0]     w_load_cnt;
    md_op_e               w_op;

    assign w_op      = md_op_e'(op);
    assign w_sprod   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_uprod   = {32'd0, A} * {32'd0, B};
    assign w_long_op = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                       (w_op == OP_DIV)  || (w_op == OP_DIVU);

    always_comb begin
        w_result   = 64'd0;
        w_load_cnt = C_MULT;
        case (w_op)
            OP_MULT:  w_result = w_sprod;
            OP_MULTU: w_result = w_uprod;
            OP_DIV: begin
                w_result   = f_sdiv($signed(A), $signed(B));
                w_load_cnt = C_DIV;
            end
            OP_DIVU: begin
                w_result   = f_udiv(A, B);
                w_load_cnt = C_DIV;
            end
            default: begin
                w_result   = 64'd0;
                w_load_cnt = C_MULT;
            end
        endcase
    end

    // Result is captured at the accepting edge and only exposed when the count expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_busy) begin
            if (r_count == C_ONE) begin
                r_busy  <= 1'b0;
                r_count <= '0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_count <= r_count - C_ONE;
            end
        end else if (start) begin
            if (w_long_op) begin
                r_pend_hi <= w_result[63:32];
                r_pend_lo <= w_result[31:0];
                // Divide by zero still runs the full latency but leaves HI/LO alone.
                r_pend_wr <= !(((w_op == OP_DIV) || (w_op == OP_DIVU)) && (B == 32'd0));
                r_count   <= w_load_cnt;
                r_busy    <= 1'b1;
            end else if (w_op == OP_MTHI) begin
                r_hi <= A;
            end else if (w_op == OP_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign busy     = r_busy;
    assign md_stall = r_busy | (start & w_long_op);
    assign HI_out   = r_hi;
    assign LO_out   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, HI/LO results, div-by-zero,
// mthi/mtlo, ignored ops while busy and asynchronous reset abort.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    int n_tests;
    int n_fail;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .md_stall (md_stall),
        .HI_out   (HI_out),
        .LO_out   (LO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op for one rising edge; returns at negedge+1 of the first cycle after it.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string tag);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        chk({tag, " stall_accept"}, {31'd0, md_stall}, {31'd0, exp_stall});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        A     = 32'hA5A5_A5A5;
        B     = 32'h5A5A_5A5A;
        #1;
    endtask

    // Expect busy/md_stall high for n sampled cycles, then both low.
    task automatic wait_busy(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy_hi"}, {31'd0, busy}, 32'd1);
            chk({tag, " stall_hi"}, {31'd0, md_stall}, 32'd1);
            @(negedge clk);
            #1;
        end
        chk({tag, " busy_lo"}, {31'd0, busy}, 32'd0);
        chk({tag, " stall_lo"}, {31'd0, md_stall}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        A       = 32'd0;
        B       = 32'd0;

        // Reset state and release
        @(negedge clk);
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst HI", HI_out, 32'd0);
        chk("rst LO", LO_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel busy", {31'd0, busy}, 32'd0);
        chk("rel stall", {31'd0, md_stall}, 32'd0);

        // Abort an in-flight divide with asynchronous reset
        issue(3'd4, 32'd7, 32'd2, 1'b1, "rst_div");
        chk("rst_div busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort HI", HI_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("post_abort busy", {31'd0, busy}, 32'd0);
        end
        chk("post_abort HI", HI_out, 32'd0);
        chk("post_abort LO", LO_out, 32'd0);

        // mult / multu
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult");
        chk("mult HI_pending", HI_out, 32'd0);
        wait_busy(5, "mult");
        chk("mult HI", HI_out, 32'hFFFF_FFFF);
        chk("mult LO", LO_out, 32'hFFFF_FFFA);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b1, "multu");
        wait_busy(5, "multu");
        chk("multu HI", HI_out, 32'h0000_0002);
        chk("multu LO", LO_out, 32'hFFFF_FFFA);

        // div / divu
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
        wait_busy(10, "div");
        chk("div LO", LO_out, 32'hFFFF_FFFD);
        chk("div HI", HI_out, 32'hFFFF_FFFF);
        issue(3'd4, 32'd7, 32'd2, 1'b1, "divu");
        wait_busy(10, "divu");
        chk("divu LO", LO_out, 32'd3);
        chk("divu HI", HI_out, 32'd1);

        // Divide by zero leaves HI/LO; signed overflow case
        issue(3'd5, 32'h11, 32'd0, 1'b0, "mthi11");
        chk("mthi11 HI", HI_out, 32'h11);
        issue(3'd6, 32'h22, 32'd0, 1'b0, "mtlo22");
        chk("mtlo22 LO", LO_out, 32'h22);
        issue(3'd4, 32'h1234, 32'd0, 1'b1, "divu0");
        wait_busy(10, "divu0");
        chk("divu0 HI", HI_out, 32'h11);
        chk("divu0 LO", LO_out, 32'h22);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divovf");
        wait_busy(10, "divovf");
        chk("divovf LO", LO_out, 32'h8000_0000);
        chk("divovf HI", HI_out, 32'd0);

        // mthi/mtlo on consecutive edges
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, "mthi");
        chk("mthi HI", HI_out, 32'hDEAD_BEEF);
        chk("mthi LO", LO_out, 32'h8000_0000);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h1234_5678, 32'd0, 1'b0, "mtlo");
        chk("mtlo LO", LO_out, 32'h1234_5678);
        chk("mtlo HI", HI_out, 32'hDEAD_BEEF);
        chk("mtlo busy", {31'd0, busy}, 32'd0);

        // mthi while busy is ignored
        issue(3'd1, 32'd5, 32'd6, 1'b1, "mult56");
        chk("mult56 busy1", {31'd0, busy}, 32'd1);
        start = 1'b1;
        op    = 3'd5;
        A     = 32'hCAFE_F00D;
        #1;
        chk("mthi_busy stall", {31'd0, md_stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        #1;
        chk("mthi_busy HI", HI_out, 32'hDEAD_BEEF);
        wait_busy(4, "mult56");
        chk("mult56 HI", HI_out, 32'd0);
        chk("mult56 LO", LO_out, 32'd30);

        // Second mult held during busy, accepted the cycle busy falls
        issue(3'd1, 32'd3, 32'd4, 1'b1, "mult34");
        start = 1'b1;
        op    = 3'd1;
        A     = 32'h0001_0000;
        B     = 32'h0001_0000;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("held busy_hi", {31'd0, busy}, 32'd1);
            @(negedge clk);
            #1;
        end
        chk("held busy_lo", {31'd0, busy}, 32'd0);
        chk("held stall", {31'd0, md_stall}, 32'd1);
        chk("mult34 HI", HI_out, 32'd0);
        chk("mult34 LO", LO_out, 32'd12);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        #1;
        wait_busy(5, "mult2nd");
        chk("mult2nd HI", HI_out, 32'd1);
        chk("mult2nd LO", LO_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
